// File: rtl/int_controller_pkg.sv
// rtl/int_controller_pkg.sv - interrupt controller defaults and vector helper
`timescale 1ns/1ps
package int_controller_pkg;
`include "int_defs.vh"

    localparam int          DEF_NUM_SRC         = `INT_NUM_SRC;
    localparam logic [31:0] DEF_VEC_BASE        = `INT_VEC_BASE;
    localparam int          DEF_VEC_STRIDE_LOG2 = `INT_VEC_STRIDE_LOG2;
    localparam int          DEF_FLUSH_CYCLES    = `INT_FLUSH_CYCLES;

    // Handler entry point for source idx.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input int          stride_log2,
                                             input logic [31:0] idx);
        return base + (idx << stride_log2);
    endfunction

endpackage

// File: rtl/int_defs.vh
// rtl/int_defs.vh - interrupt controller defaults shared with CP0/EX decode
`ifndef INT_DEFS_VH
`define INT_DEFS_VH
`define INT_NUM_SRC         3
`define INT_VEC_BASE        32'h0000_1000
`define INT_VEC_STRIDE_LOG2 4
`define INT_FLUSH_CYCLES    2
`endif

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - highest-set-bit priority encoder
`timescale 1ns/1ps
module int_prio_enc #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    // Scan upward so the highest set bit is the one left in idx_o.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

    assign vld_o = |vec_i;

endmodule

// File: rtl/int_controller.sv
// rtl/int_controller.sv - nested prioritised interrupt source for the EX redirect path
`timescale 1ns/1ps
module int_controller
    import int_controller_pkg::*;
#(
    parameter int          NUM_SRC         = DEF_NUM_SRC,
    parameter logic [31:0] VEC_BASE        = DEF_VEC_BASE,
    parameter int          VEC_STRIDE_LOG2 = DEF_VEC_STRIDE_LOG2,
    parameter int          FLUSH_CYCLES    = DEF_FLUSH_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] IRQ_In,
    input  logic [NUM_SRC-1:0] IRQ_Mask,
    input  logic               IE,
    input  logic               EX_Valid,
    input  logic               ERET,
    input  logic [31:0]        EX_NOINT_NextPC,
    output logic               IntRequest,
    output logic [31:0]        Int_NextPC,
    output logic [31:0]        EPC_Out,
    output logic [NUM_SRC-1:0] Pending,
    output logic [NUM_SRC-1:0] InService
);

    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SP_W   = $clog2(NUM_SRC + 1);
    localparam int COOL_W = $clog2(FLUSH_CYCLES + 1);

    logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_SRC-1:0] pending_q, pending_d, inservice_q, inservice_d;
    logic [NUM_SRC-1:0] rise, grant_oh, isr_top_oh;
    logic [IDX_W-1:0]   cand_idx, isr_idx;
    logic               cand_vld, isr_vld, eligible, int_req, eret_take;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [COOL_W-1:0]  cool_q, cool_d;
    logic [31:0]        stack_q [NUM_SRC];
    logic [31:0]        epc_q, epc_d, pop_top;

    int_prio_enc #(.N(NUM_SRC), .IDX_W(IDX_W)) u_cand_enc (
        .vec_i (pending_q & IRQ_Mask),
        .idx_o (cand_idx),
        .vld_o (cand_vld)
    );

    int_prio_enc #(.N(NUM_SRC), .IDX_W(IDX_W)) u_isr_enc (
        .vec_i (inservice_q),
        .idx_o (isr_idx),
        .vld_o (isr_vld)
    );

    // Only a strictly higher level may preempt; ERET always beats a new grant.
    assign eligible   = cand_vld & (~isr_vld | (cand_idx > isr_idx));
    assign int_req    = IE & EX_Valid & ~ERET & (cool_q == '0) & eligible;
    assign eret_take  = ERET & (sp_q != '0);
    assign rise       = sync2_q & ~sync3_q;
    assign grant_oh   = int_req ? (NUM_SRC'(1) << cand_idx) : '0;
    assign isr_top_oh = NUM_SRC'(1) << isr_idx;

    // EPC that becomes the top of stack after a pop (entry at sp-2).
    always_comb begin
        pop_top = '0;
        for (int i = 0; i < NUM_SRC - 1; i++) begin
            if (sp_q == SP_W'(i + 2)) pop_top = stack_q[i];
        end
    end

    // Next-state for pending/in-service tracking, stack pointer, cooldown and EPC top.
    always_comb begin
        pending_d   = (pending_q | rise) & ~grant_oh;
        inservice_d = inservice_q;
        sp_d        = sp_q;
        epc_d       = epc_q;
        cool_d      = (cool_q != '0) ? cool_q - COOL_W'(1) : cool_q;
        if (int_req) begin
            inservice_d = inservice_q | grant_oh;
            sp_d        = sp_q + SP_W'(1);
            cool_d      = COOL_W'(FLUSH_CYCLES);
            epc_d       = EX_NOINT_NextPC;
        end else if (eret_take) begin
            inservice_d = inservice_q & ~isr_top_oh;
            sp_d        = sp_q - SP_W'(1);
            cool_d      = COOL_W'(FLUSH_CYCLES);
            epc_d       = pop_top;
        end
    end

    // Two-flop synchroniser plus a delayed copy for rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= IRQ_In;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            inservice_q <= '0;
            sp_q        <= '0;
            cool_q      <= '0;
            epc_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            inservice_q <= inservice_d;
            sp_q        <= sp_d;
            cool_q      <= cool_d;
            epc_q       <= epc_d;
        end
    end

    // EPC stack storage; a grant writes the slot at the current sp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) stack_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (int_req && (sp_q == SP_W'(i))) stack_q[i] <= EX_NOINT_NextPC;
            end
        end
    end

    assign IntRequest = int_req;
    assign Int_NextPC = vec_addr(VEC_BASE, VEC_STRIDE_LOG2, 32'(cand_idx));
    assign EPC_Out    = epc_q;
    assign Pending    = pending_q;
    assign InService  = inservice_q;

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - scoreboard bench for int_controller
`timescale 1ns/1ps
module tb_int_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  IRQ_In, IRQ_Mask;
    logic        IE, EX_Valid, ERET;
    logic [31:0] EX_NOINT_NextPC;
    logic        IntRequest;
    logic [31:0] Int_NextPC, EPC_Out;
    logic [2:0]  Pending, InService;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [2:0]  isr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   grants   = 0;

    int_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IRQ_In          (IRQ_In),
        .IRQ_Mask        (IRQ_Mask),
        .IE              (IE),
        .EX_Valid        (EX_Valid),
        .ERET            (ERET),
        .EX_NOINT_NextPC (EX_NOINT_NextPC),
        .IntRequest      (IntRequest),
        .Int_NextPC      (Int_NextPC),
        .EPC_Out         (EPC_Out),
        .Pending         (Pending),
        .InService       (InService)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] epc, input logic [2:0] isr);
        exp_t e;
        e.pc  = pc;
        e.epc = epc;
        e.isr = isr;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input int i);
        IRQ_In[i] = 1'b1;
        step();
        IRQ_In[i] = 1'b0;
    endtask

    task automatic wait_req(input int max);
        int n;
        n = 0;
        #1;
        while (!IntRequest && n < max) begin
            step();
            n++;
        end
        checks++;
        if (!IntRequest) begin
            failures++;
            $display("FAIL wait_req timeout actual=0 expected=1 after %0d cycles", max);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pending"},  32'(Pending),    32'h0);
        chk({tag, "_insvc"},    32'(InService),  32'h0);
        chk({tag, "_intreq"},   32'(IntRequest), 32'h0);
        chk({tag, "_nextpc"},   Int_NextPC,      32'h0000_1000);
        chk({tag, "_epc"},      EPC_Out,         32'h0);
    endtask

    // Scoreboard monitor: each grant is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && IntRequest) begin
                grants++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant actual_pc=%h expected=none", Int_NextPC);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_pc", Int_NextPC, e.pc);
                    @(negedge clk);
                    chk("grant_epc", EPC_Out, e.epc);
                    chk("grant_isr", 32'(InService), 32'(e.isr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        IRQ_In = '0; IRQ_Mask = 3'b111; IE = 1'b1; EX_Valid = 1'b1; ERET = 1'b0;
        EX_NOINT_NextPC = 32'h0040_0024;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        step();

        // 1: single source 0
        push_exp(32'h0000_1000, 32'h0040_0024, 3'b001);
        IRQ_In[0] = 1'b1;
        step();
        IRQ_In[0] = 1'b0;
        #1 chk("t1_pend_e1", 32'(Pending), 32'h0);
        step();
        chk("t1_pend_e2", 32'(Pending), 32'h0);
        step();
        chk("t1_pend_e3", 32'(Pending), 32'h1);
        chk("t1_intreq", 32'(IntRequest), 32'h1);
        chk("t1_nextpc", Int_NextPC, 32'h0000_1000);
        step();
        chk("t1_pend_clr", 32'(Pending), 32'h0);
        chk("t1_insvc", 32'(InService), 32'h1);
        chk("t1_epc", EPC_Out, 32'h0040_0024);
        chk("t1_cooldown", 32'(IntRequest), 32'h0);

        // 2: nest source 2 over 0, then unwind
        step(); step();
        EX_NOINT_NextPC = 32'h0040_0100;
        push_exp(32'h0000_1020, 32'h0040_0100, 3'b101);
        pulse(2);
        wait_req(5);
        step();
        chk("t2_insvc", 32'(InService), 32'h5);
        chk("t2_epc", EPC_Out, 32'h0040_0100);
        step(); step();
        ERET = 1'b1;
        step();
        ERET = 1'b0;
        #1 chk("t2_pop1_epc", EPC_Out, 32'h0040_0024);
        chk("t2_pop1_insvc", 32'(InService), 32'h1);
        step(); step();
        ERET = 1'b1;
        step();
        ERET = 1'b0;
        #1 chk("t2_pop2_epc", EPC_Out, 32'h0);
        chk("t2_pop2_insvc", 32'(InService), 32'h0);

        // 3: lower priority waits for ERET of level 2, then flush window
        step(); step();
        EX_NOINT_NextPC = 32'h0000_0200;
        push_exp(32'h0000_1020, 32'h0000_0200, 3'b100);
        pulse(2);
        wait_req(5);
        step(); step(); step();
        pulse(1);
        step(); step();
        chk("t3_pend", 32'(Pending), 32'h2);
        chk("t3_blocked", 32'(IntRequest), 32'h0);
        step(); step();
        chk("t3_still_blocked", 32'(IntRequest), 32'h0);
        EX_NOINT_NextPC = 32'h0000_0300;
        push_exp(32'h0000_1010, 32'h0000_0300, 3'b010);
        ERET = 1'b1;
        step();
        ERET = 1'b0;
        #1 chk("t3_flush1", 32'(IntRequest), 32'h0);
        step();
        chk("t3_flush2", 32'(IntRequest), 32'h0);
        step();
        chk("t3_after_flush", 32'(IntRequest), 32'h1);
        chk("t3_nextpc", Int_NextPC, 32'h0000_1010);
        step();
        chk("t3_insvc", 32'(InService), 32'h2);

        // 4: ERET and eligible candidate in the same cycle
        step(); step();
        IE = 1'b0;
        pulse(2);
        step(); step();
        chk("t4_pend_ie_off", 32'(Pending), 32'h4);
        chk("t4_ie_off", 32'(IntRequest), 32'h0);
        EX_NOINT_NextPC = 32'h0000_0400;
        push_exp(32'h0000_1020, 32'h0000_0400, 3'b100);
        IE = 1'b1;
        ERET = 1'b1;
        #1 chk("t4_eret_wins", 32'(IntRequest), 32'h0);
        step();
        ERET = 1'b0;
        #1 chk("t4_pend_held", 32'(Pending), 32'h4);
        chk("t4_insvc_pop", 32'(InService), 32'h0);
        chk("t4_epc_pop", EPC_Out, 32'h0);
        chk("t4_flush1", 32'(IntRequest), 32'h0);
        step();
        chk("t4_flush2", 32'(IntRequest), 32'h0);
        step();
        chk("t4_fire", 32'(IntRequest), 32'h1);
        step();
        chk("t4_insvc", 32'(InService), 32'h4);

        // 5: gating by IE / EX_Valid / mask, and ERET with empty stack
        step(); step();
        ERET = 1'b1;
        step();
        ERET = 1'b0;
        step();
        IRQ_Mask = 3'b110; EX_Valid = 1'b0; IE = 1'b0;
        pulse(0);
        step(); step();
        chk("t5_pend", 32'(Pending), 32'h1);
        chk("t5_gated", 32'(IntRequest), 32'h0);
        ERET = 1'b1;
        step();
        ERET = 1'b0;
        #1 chk("t5_empty_eret_pend", 32'(Pending), 32'h1);
        chk("t5_empty_eret_insvc", 32'(InService), 32'h0);
        chk("t5_empty_eret_epc", EPC_Out, 32'h0);
        IE = 1'b1;
        #1 chk("t5_ex_invalid", 32'(IntRequest), 32'h0);
        EX_Valid = 1'b1;
        #1 chk("t5_masked", 32'(IntRequest), 32'h0);
        EX_NOINT_NextPC = 32'h0000_0500;
        push_exp(32'h0000_1000, 32'h0000_0500, 3'b001);
        IRQ_Mask = 3'b111;
        #1 chk("t5_all_enabled", 32'(IntRequest), 32'h1);
        step();
        chk("t5_insvc", 32'(InService), 32'h1);

        // 6: async reset at nesting depth 2
        step(); step();
        EX_NOINT_NextPC = 32'h0000_0600;
        push_exp(32'h0000_1010, 32'h0000_0600, 3'b011);
        pulse(1);
        wait_req(5);
        step();
        chk("t6_insvc", 32'(InService), 32'h3);
        chk("t6_epc", EPC_Out, 32'h0000_0600);
        step();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        step();
        rst_n = 1'b1;
        step();
        chk("t6_post_pend", 32'(Pending), 32'h0);
        chk("t6_post_insvc", 32'(InService), 32'h0);

        step();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        chk("grant_count", 32'(grants), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
